note_lane_scroller: RTL and testbench

//  One-lane falling-note engine for the Guitar Hero display path. Accepts spawn requests from the song

---
 rtl/note_lane_scroller.sv | 167 ++++++++++++++++
 tb/tb_note_lane_scroller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/note_lane_scroller.sv
// note_lane_scroller
//   One-lane falling-note engine. Spawns a note on request, moves it down by cur_speed pixels on
//   every unpaused frame tick, and judges strums as hit / miss / bad. Geometry outputs feed the
//   per-pixel bounds checker directly.
//
// Ports
//   i_clock            system clock (VGA domain)
//   i_reset_n          synchronous active-low reset
//   i_frame_tick       one-cycle pulse per frame
//   i_pause            freeze motion and ignore strums
//   i_spawn_valid      sequencer requests a new note
//   o_spawn_ready      high while the lane is idle
//   i_strum            one-cycle debounced strum for this lane
//   o_note_active      high while a note is on screen
//   o_note_x           lane left edge (constant)
//   o_note_y           note top edge; all-ones while idle so nothing is drawn
//   o_note_width_x/y   note size (constant)
//   o_hit_pulse        registered: strum landed inside the hit window
//   o_miss_pulse       registered: note fell past the miss line
//   o_bad_strum_pulse  registered: strum with no note in the window
//   o_cur_speed        current pixels per frame
//
// Configuration macro: SCROLL_SPEEDUP_EN
//   Defined:   every 8th hit raises cur_speed by 1, saturating at MAX_SPEED.
//   Undefined: cur_speed is the constant SPEED.

module note_lane_scroller #(
  parameter int unsigned LANE_X    = 100,
  parameter int unsigned NOTE_W    = 40,
  parameter int unsigned NOTE_H    = 16,
  parameter int unsigned SPAWN_Y   = 0,
  parameter int unsigned HIT_Y_LO  = 400,
  parameter int unsigned HIT_Y_HI  = 440,
  parameter int unsigned MISS_Y    = 470,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned MAX_SPEED = 12
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_frame_tick,
  input  logic        i_pause,
  input  logic        i_spawn_valid,
  output logic        o_spawn_ready,
  input  logic        i_strum,
  output logic        o_note_active,
  output logic [9:0]  o_note_x,
  output logic [31:0] o_note_y,
  output logic [6:0]  o_note_width_x,
  output logic [6:0]  o_note_width_y,
  output logic        o_hit_pulse,
  output logic        o_miss_pulse,
  output logic        o_bad_strum_pulse,
  output logic [3:0]  o_cur_speed
);

  typedef enum logic [0:0] {StIdle, StFall} state_e;

  localparam logic [31:0] IdleY = 32'hFFFF_FFFF;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_note_y;
  logic [31:0] w_note_y_next;
  logic        r_hit;
  logic        r_miss;
  logic        r_bad;
  logic [3:0]  w_speed;
  logic [31:0] w_y_adv;
  logic        w_in_window;
  logic        w_strum_en;
  logic        w_fall_run;
  logic        w_spawn;
  logic        w_hit;
  logic        w_miss;
  logic        w_bad;
  logic        w_move;

`ifdef SCROLL_SPEEDUP_EN
  logic [2:0] r_hit_cnt;
  logic [3:0] r_speed;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_hit_cnt <= '0;
      r_speed   <= 4'(SPEED);
    end else if (w_hit) begin
      r_hit_cnt <= r_hit_cnt + 3'd1;
      // Counter wraps 7 -> 0 on the 8th hit, which is when the speed steps up.
      if (r_hit_cnt == 3'd7 && r_speed < 4'(MAX_SPEED)) begin
        r_speed <= r_speed + 4'd1;
      end
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = (SPEED > MAX_SPEED) ? 4'(MAX_SPEED) : 4'(SPEED);
`endif

  // Event decode. Priority: hit, then miss, then bad strum, so at most one pulse fires.
  assign w_y_adv     = r_note_y + 32'(w_speed);
  assign w_in_window = (r_note_y >= HIT_Y_LO) && (r_note_y <= HIT_Y_HI);
  assign w_strum_en  = i_strum & ~i_pause;
  assign w_fall_run  = (r_state == StFall) & ~i_pause;
  assign w_spawn     = i_spawn_valid & (r_state == StIdle);
  assign w_hit       = w_fall_run & i_strum & w_in_window;
  assign w_miss      = w_fall_run & i_frame_tick & ~w_hit & (w_y_adv > MISS_Y);
  assign w_bad       = w_strum_en & ~w_hit & ~w_miss;
  assign w_move      = w_fall_run & i_frame_tick & ~w_hit & ~w_miss;

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_spawn) w_state_next = StFall;
      StFall: if (w_hit || w_miss) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_note_y_next = r_note_y;
    if (w_spawn) begin
      w_note_y_next = 32'(SPAWN_Y);
    end else if (w_hit || w_miss) begin
      w_note_y_next = IdleY;
    end else if (w_move) begin
      w_note_y_next = w_y_adv;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_note_y <= IdleY;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_note_y <= w_note_y_next;
      r_hit    <= w_hit;
      r_miss   <= w_miss;
      r_bad    <= w_bad;
    end
  end

  assign o_spawn_ready     = (r_state == StIdle);
  assign o_note_active     = (r_state == StFall);
  assign o_note_x          = 10'(LANE_X);
  assign o_note_y          = r_note_y;
  assign o_note_width_x    = 7'(NOTE_W);
  assign o_note_width_y    = 7'(NOTE_H);
  assign o_hit_pulse       = r_hit;
  assign o_miss_pulse      = r_miss;
  assign o_bad_strum_pulse = r_bad;
  assign o_cur_speed       = w_speed;

endmodule

// File: tb/tb_note_lane_scroller.sv
module tb_note_lane_scroller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;
  logic        spawn_valid = 1'b0;
  logic        strum = 1'b0;
  logic        spawn_ready;
  logic        note_active;
  logic [9:0]  note_x;
  logic [31:0] note_y;
  logic [6:0]  note_width_x;
  logic [6:0]  note_width_y;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        bad_strum_pulse;
  logic [3:0]  cur_speed;

  int checks = 0;
  int failures = 0;

  // Reference model state, kept as plain integers.
  bit          m_active;
  int unsigned m_y;
  int unsigned m_speed;
  int unsigned m_hits;
  bit          e_hit, e_miss, e_bad;

  note_lane_scroller dut (
    .i_clock          (clock),
    .i_reset_n        (reset_n),
    .i_frame_tick     (frame_tick),
    .i_pause          (pause),
    .i_spawn_valid    (spawn_valid),
    .o_spawn_ready    (spawn_ready),
    .i_strum          (strum),
    .o_note_active    (note_active),
    .o_note_x         (note_x),
    .o_note_y         (note_y),
    .o_note_width_x   (note_width_x),
    .o_note_width_y   (note_width_y),
    .o_hit_pulse      (hit_pulse),
    .o_miss_pulse     (miss_pulse),
    .o_bad_strum_pulse(bad_strum_pulse),
    .o_cur_speed      (cur_speed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural rules: one call per clock edge.
  task automatic model(input bit rn, input bit ft, input bit ps, input bit sv, input bit st);
    e_hit = 0; e_miss = 0; e_bad = 0;
    if (!rn) begin
      m_active = 0; m_y = 32'hFFFF_FFFF; m_speed = 4; m_hits = 0;
      return;
    end
    if (!m_active) begin
      if (st && !ps) e_bad = 1;
      if (sv) begin m_active = 1; m_y = 0; end
    end else if (!ps) begin
      if (st && m_y >= 400 && m_y <= 440) begin
        e_hit = 1; m_active = 0; m_y = 32'hFFFF_FFFF;
        m_hits++;
`ifdef SCROLL_SPEEDUP_EN
        if (m_hits % 8 == 0 && m_speed < 12) m_speed++;
`endif
      end else begin
        if (ft) begin
          if (m_y + m_speed > 470) begin
            e_miss = 1; m_active = 0; m_y = 32'hFFFF_FFFF;
          end else begin
            m_y = m_y + m_speed;
          end
        end
        if (st && !e_miss) e_bad = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("note_y", note_y, m_y);
    chk("note_active", 32'(note_active), 32'(m_active));
    chk("spawn_ready", 32'(spawn_ready), 32'(!m_active));
    chk("hit_pulse", 32'(hit_pulse), 32'(e_hit));
    chk("miss_pulse", 32'(miss_pulse), 32'(e_miss));
    chk("bad_strum_pulse", 32'(bad_strum_pulse), 32'(e_bad));
    chk("cur_speed", 32'(cur_speed), m_speed);
  endtask

  task automatic step(input bit rn, input bit ft, input bit ps, input bit sv, input bit st);
    reset_n = rn; frame_tick = ft; pause = ps; spawn_valid = sv; strum = st;
    model(rn, ft, ps, sv, st);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
  endtask

  initial begin
    int guard;
    // Reset held with spawn_valid asserted.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 1);
    chk("const_note_x", 32'(note_x), 32'd100);
    chk("const_width_x", 32'(note_width_x), 32'd40);
    chk("const_width_y", 32'(note_width_y), 32'd16);
    chk("reset_y", note_y, 32'hFFFF_FFFF);
    step(1, 0, 0, 1, 0);
    chk("spawn_y0", note_y, 32'd0);

    // Hit at 400.
    ticks(100);
    chk("y_after_100", note_y, 32'd400);
    step(1, 0, 0, 0, 1);
    chk("hit_seen", 32'(hit_pulse), 32'd1);
    step(1, 0, 0, 0, 0);

    // Miss after 118 ticks.
    step(1, 0, 0, 1, 0);
    ticks(117);
    chk("y_after_117", note_y, 32'd468);
    step(1, 1, 0, 0, 0);
    chk("miss_seen", 32'(miss_pulse), 32'd1);
    step(1, 0, 0, 0, 0);

    // Bad strum at 200, then pause freezes motion and strums.
    step(1, 0, 0, 1, 0);
    ticks(50);
    step(1, 0, 0, 0, 1);
    chk("bad_seen", 32'(bad_strum_pulse), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, i == 3);
    chk("paused_y", note_y, 32'd200);

    // Spawn while busy is ignored.
    step(1, 0, 0, 1, 0);

    // Strum with tick at 440: hit, no move.
    ticks(60);
    chk("y_440", note_y, 32'd440);
    step(1, 1, 0, 0, 1);
    chk("edge_hit", 32'(hit_pulse), 32'd1);

    // Strum in idle.
    step(1, 0, 0, 0, 1);

    // Mid-fall reset.
    step(1, 0, 0, 1, 0);
    ticks(20);
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);

    // Repeated hits exercise the speedup path (speed stays constant without it).
    for (int h = 0; h < 72; h++) begin
      step(1, 0, 0, 1, 0);
      guard = 0;
      while (m_y < 400 && guard < 200) begin
        step(1, 1, 0, 0, 0);
        guard++;
      end
      step(1, 0, 0, 0, 1);
    end
`ifdef SCROLL_SPEEDUP_EN
    chk("speed_sat", 32'(cur_speed), 32'd12);
`else
    chk("speed_const", 32'(cur_speed), 32'd4);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit ft, ps, sv, st, rn;
      ft = ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 15) == 0);
      sv = ($urandom_range(0, 3) == 0);
      st = (m_active && m_y >= 400 && m_y <= 440) ? ($urandom_range(0, 3) == 0)
                                                  : ($urandom_range(0, 63) == 0);
      rn = ($urandom_range(0, 499) != 0);
      step(rn, ft, ps, sv, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
